pipe_skid_stage_reg: RTL and testbench
======================================

// Module: pipe_skid_stage_reg
// PURPOSE
//  Generic elastic pipeline-stage register: successor to fixed-field stall-only stage regs (IF/ID, ID/EX, ...).
//  Carries a DATA_W payload plus CTRL_W control bits with valid/ready handshake, 2-entry skid buffer,
//  synchronous flush (bubble insert) and a saturating stall counter. Sits between any two pipeline stages.
//  IN_READY is registered, so no combinational ready path crosses the stage.
// PARAMETERS
//  DATA_W      128   payload width (PC, operands, immediate, ...)
//  CTRL_W      24    control-bit width (ALU op, sels, mem R/W, WB sel, reg-write enable)
//  CTRL_BUBBLE 0     CTRL value driven when OUT_VALID=0 (must encode no mem access, no reg write)
//  CNT_W       16    stall counter width
// PORTS
//  CLK        in   1       clock, all state updates on posedge
//  RESET      in   1       synchronous, active-high
//  FLUSH      in   1       discard all held entries (branch/jump redirect)
//  IN_VALID   in   1       upstream entry present
//  IN_READY   out  1       stage can accept (registered)
//  IN_DATA    in   DATA_W  upstream payload
//  IN_CTRL    in   CTRL_W  upstream control bits
//  OUT_VALID  out  1       entry present at output
//  OUT_READY  in   1       downstream accepts
//  OUT_DATA   out  DATA_W  held payload
//  OUT_CTRL   out  CTRL_W  held control; CTRL_BUBBLE whenever OUT_VALID=0
//  STALL_CNT  out  CNT_W   cycles with OUT_VALID=1 and OUT_READY=0, saturating
// BEHAVIOUR
//  Reset (RESET=1 at posedge): OUT_VALID=0, OUT_DATA=0, OUT_CTRL=CTRL_BUBBLE, skid empty, STALL_CNT=0,
//   IN_READY=0 while RESET held; IN_READY=1 from the first posedge with RESET=0. RESET beats FLUSH and all handshakes.
//  Accept = IN_VALID & IN_READY; drain = OUT_VALID & OUT_READY (both sampled at posedge).
//  States: EMPTY (main invalid), FULL (main valid, skid empty), SKID (both valid).
//   EMPTY: accept -> FULL, main<=IN. No accept -> EMPTY.
//   FULL : accept&drain -> FULL, main<=IN. accept&!drain -> SKID, skid<=IN. !accept&drain -> EMPTY. else hold.
//   SKID : IN_READY=0, no accept. drain -> FULL, main<=skid. else hold.
//  IN_READY = next-state != SKID (registered).
//  Latency 1 cycle accept->OUT_VALID when empty/draining; throughput 1/cycle; strict FIFO order.
//  OUT_DATA/OUT_CTRL stable while OUT_VALID & !OUT_READY; skid contents never visible at output.
//  FLUSH=1 at posedge: next state EMPTY, any accept in the same cycle is discarded, drain in that cycle
//   still counts as completed downstream; OUT_CTRL=CTRL_BUBBLE next cycle; OUT_DATA unchanged (don't-care);
//   IN_READY=1 next cycle.
//  STALL_CNT: +1 each posedge with OUT_VALID & !OUT_READY; holds at 2^CNT_W-1; cleared by RESET only,
//   not by FLUSH.
//  No X ever driven on any output after the first reset posedge.
// TESTING
//  T1 reset: RESET=1 2 cycles -> OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, IN_READY=0, STALL_CNT=0; IN_READY=1 after release.
//  T2 streaming: OUT_READY=1, IN_VALID=1, data 1..8 on consecutive cycles -> OUT_DATA 1..8 one cycle later,
//   no gaps, IN_READY never drops.
//  T3 backpressure: stream 0xA,0xB,0xC, OUT_READY=0 at cycle 2 for 3 cycles -> 0xA held, 0xB in skid,
//   IN_READY=0, 0xC held upstream; STALL_CNT=3; on release outputs 0xA,0xB,0xC in order, none lost/duplicated.
//  T4 flush in SKID with IN_VALID=1 -> next cycle OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, IN_READY=1,
//   flushed entries never appear; STALL_CNT unchanged.
//  T5 saturation: CNT_W=4, hold OUT_READY=0 for 20 cycles with valid entry -> STALL_CNT stops at 15.
//  T6 RESET asserted in SKID state with FLUSH=1 -> reset values next cycle; random valid/ready soak
//   (10k cycles) vs. scoreboard: order preserved, zero drops.

Source files
------------

// File: rtl/pipe_skid_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage_reg
// Purpose  : Elastic pipeline-stage register with a valid/ready handshake.
//            It carries a DATA_W payload and CTRL_W control bits, and has a
//            2-entry skid buffer (main + skid), a synchronous flush that
//            inserts a bubble, and a saturating stall counter.
//            IN_READY is a flop output, so no combinational ready path
//            crosses this stage.
// Ports    : CLK        - clock; all state updates on posedge
//            RESET      - synchronous, active-high
//            FLUSH      - discard every held entry (redirect)
//            IN_VALID   - upstream entry present
//            IN_READY   - stage can accept (registered)
//            IN_DATA    - upstream payload
//            IN_CTRL    - upstream control bits
//            OUT_VALID  - entry present at output
//            OUT_READY  - downstream accepts
//            OUT_DATA   - held payload
//            OUT_CTRL   - held control; CTRL_BUBBLE whenever OUT_VALID=0
//            STALL_CNT  - saturating count of OUT_VALID & !OUT_READY cycles
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage_reg #(
    parameter int unsigned          DATA_W      = 128,
    parameter int unsigned          CTRL_W      = 24,
    parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = '0,
    parameter int unsigned          CNT_W       = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FLUSH,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [DATA_W-1:0]   IN_DATA,
    input  logic [CTRL_W-1:0]   IN_CTRL,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [DATA_W-1:0]   OUT_DATA,
    output logic [CTRL_W-1:0]   OUT_CTRL,
    output logic [CNT_W-1:0]    STALL_CNT
);

    // ------------------------------------------------------------------
    // State encoding
    //   EMPTY : main register invalid
    //   FULL  : main register valid, skid empty
    //   SKID  : main and skid both valid (upstream is held off)
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]         state;
    logic [1:0]         state_nxt;

    logic [DATA_W-1:0]  main_data;
    logic [CTRL_W-1:0]  main_ctrl;
    logic [DATA_W-1:0]  skid_data;
    logic [CTRL_W-1:0]  skid_ctrl;

    logic               in_ready_q;
    logic [CNT_W-1:0]   stall_cnt;

    logic               out_valid;
    logic               accept;
    logic               drain;
    logic               stalled;

    // Register-load selects produced by the next-state logic
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign out_valid = (state == ST_FULL) || (state == ST_SKID);
    assign accept    = IN_VALID  & in_ready_q;
    assign drain     = out_valid & OUT_READY;
    assign stalled   = out_valid & ~OUT_READY;

    // ------------------------------------------------------------------
    // Next-state and load-select logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt    = ST_FULL;
                    load_main_in = 1'b1;
                end
            end

            ST_FULL: begin
                if (accept && drain) begin
                    // Pass-through at full throughput: replace the main entry
                    load_main_in = 1'b1;
                end else if (accept) begin
                    // Downstream stalled while upstream delivered: park it
                    state_nxt = ST_SKID;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end
            end

            ST_SKID: begin
                // IN_READY is low here, so only the drain side can move.
                if (drain) begin
                    state_nxt      = ST_FULL;
                    load_main_skid = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase

        // A flush empties the stage and drops any same-cycle accept. A drain
        // in this cycle has already completed downstream, so nothing to undo.
        if (FLUSH) begin
            state_nxt      = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and registered ready
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Ready is a pure function of where the stage is going, which
            // keeps the upstream ready path free of any combinational logic.
            in_ready_q <= (state_nxt != ST_SKID);
        end
    end

    // ------------------------------------------------------------------
    // Main (output) register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_data <= '0;
            main_ctrl <= CTRL_BUBBLE;
        end else if (load_main_in) begin
            main_data <= IN_DATA;
            main_ctrl <= IN_CTRL;
        end else if (load_main_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
        end
    end

    // ------------------------------------------------------------------
    // Skid register: never visible at the output directly
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            skid_data <= '0;
            skid_ctrl <= CTRL_BUBBLE;
        end else if (load_skid) begin
            skid_data <= IN_DATA;
            skid_ctrl <= IN_CTRL;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter; only RESET clears it, FLUSH does not.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The control field is forced to the bubble encoding whenever
    // nothing is valid, so a stale op can never cause a side effect.
    // ------------------------------------------------------------------
    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid;
    assign OUT_DATA  = main_data;
    assign OUT_CTRL  = out_valid ? main_ctrl : CTRL_BUBBLE;
    assign STALL_CNT = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage_reg
// Purpose  : Self-checking bench for pipe_skid_stage_reg. A queue-based
//            reference (at most two held entries, FIFO order, registered
//            ready) predicts every output; directed steps plus a random soak.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage_reg;

    localparam int              DW      = 128;
    localparam int              CW      = 24;
    localparam int              NW      = 4;
    localparam logic [CW-1:0]   BUBBLE  = 24'h5A0003;
    localparam int              CMAX    = 15;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } entry_t;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           FLUSH;
    logic           IN_VALID;
    logic           IN_READY;
    logic [DW-1:0]  IN_DATA;
    logic [CW-1:0]  IN_CTRL;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [DW-1:0]  OUT_DATA;
    logic [CW-1:0]  OUT_CTRL;
    logic [NW-1:0]  STALL_CNT;

    pipe_skid_stage_reg #(
        .DATA_W      (DW),
        .CTRL_W      (CW),
        .CTRL_BUBBLE (BUBBLE),
        .CNT_W       (NW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .IN_CTRL   (IN_CTRL),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_CTRL  (OUT_CTRL),
        .STALL_CNT (STALL_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    entry_t         m_q[$];
    logic [DW-1:0]  m_log[$];
    bit             m_ready;
    int             m_cnt;
    bit             m_acc;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one posedge to the model using the inputs the DUT sampled.
    task automatic model_edge();
        bit drn;
        entry_t e;
        m_acc = IN_VALID && m_ready;
        drn   = (m_q.size() > 0) && OUT_READY;
        if (RESET) begin
            m_q.delete();
            m_ready = 0;
            m_cnt   = 0;
            m_acc   = 0;
        end else begin
            if ((m_q.size() > 0) && !OUT_READY && (m_cnt < CMAX)) m_cnt++;
            if (drn) m_log.push_back(m_q.pop_front().data);
            if (FLUSH) begin
                m_q.delete();
                m_acc = 0;
            end else if (m_acc) begin
                e.data = IN_DATA;
                e.ctrl = IN_CTRL;
                m_q.push_back(e);
            end
            m_ready = (m_q.size() < 2);
        end
    endtask

    task automatic check_all();
        chk("in_ready", IN_READY, m_ready);
        chk("out_valid", OUT_VALID, m_q.size() > 0);
        chk("out_ctrl", OUT_CTRL, (m_q.size() > 0) ? m_q[0].ctrl : BUBBLE);
        chk("stall_cnt", STALL_CNT, m_cnt);
        if (m_q.size() > 0) chk("out_data", OUT_DATA, m_q[0].data);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic put(input logic [DW-1:0] d);
        IN_VALID = 1'b1;
        IN_DATA  = d;
        IN_CTRL  = CW'($urandom);
    endtask

    initial begin
        int cnt_before;
        RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        IN_DATA = '0; IN_CTRL = '0;

        // T1: reset for two cycles, then release
        cycle();
        cycle();
        chk("t1_valid", OUT_VALID, 1'b0);
        chk("t1_ctrl", OUT_CTRL, BUBBLE);
        chk("t1_ready", IN_READY, 1'b0);
        chk("t1_cnt", STALL_CNT, 0);
        chk("t1_data", OUT_DATA, 0);
        RESET = 1'b0;
        cycle();
        chk("t1_ready_rel", IN_READY, 1'b1);

        // T2: streaming 1..8 with OUT_READY held high
        OUT_READY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            put(DW'(i));
            cycle();
            chk("t2_data", OUT_DATA, DW'(i));
            chk("t2_valid", OUT_VALID, 1'b1);
            chk("t2_ready", IN_READY, 1'b1);
        end
        IN_VALID = 1'b0;
        cycle();

        // T3: backpressure with A,B,C
        m_log.delete();
        put(DW'(8'hA)); cycle();
        OUT_READY = 1'b0;
        put(DW'(8'hB)); cycle();
        put(DW'(8'hC)); cycle();
        cycle();
        chk("t3_cnt", STALL_CNT, 3);
        chk("t3_held", OUT_DATA, DW'(8'hA));
        chk("t3_ready", IN_READY, 1'b0);
        OUT_READY = 1'b1;
        cycle();
        chk("t3_b", OUT_DATA, DW'(8'hB));
        cycle();
        chk("t3_c", OUT_DATA, DW'(8'hC));
        IN_VALID = 1'b0;
        cycle();
        chk("t3_n", m_log.size(), 3);
        if (m_log.size() == 3) begin
            chk("t3_o0", m_log[0], DW'(8'hA));
            chk("t3_o1", m_log[1], DW'(8'hB));
            chk("t3_o2", m_log[2], DW'(8'hC));
        end

        // T4: flush while in SKID with IN_VALID high
        OUT_READY = 1'b0;
        put(DW'(16'hF001)); cycle();
        put(DW'(16'hF002)); cycle();
        chk("t4_skid_ready", IN_READY, 1'b0);
        cnt_before = m_cnt;
        FLUSH = 1'b1; OUT_READY = 1'b1;
        put(DW'(16'hF003)); cycle();
        FLUSH = 1'b0;
        chk("t4_valid", OUT_VALID, 1'b0);
        chk("t4_ctrl", OUT_CTRL, BUBBLE);
        chk("t4_ready", IN_READY, 1'b1);
        chk("t4_cnt", STALL_CNT, cnt_before);
        IN_VALID = 1'b0;
        cycle();
        chk("t4_empty", OUT_VALID, 1'b0);

        // T5: saturation with a stuck valid entry
        OUT_READY = 1'b0;
        put(DW'(16'h5A5A)); cycle();
        IN_VALID = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        chk("t5_sat", STALL_CNT, CMAX);
        OUT_READY = 1'b1;
        cycle();

        // T6: reset while in SKID with FLUSH asserted
        OUT_READY = 1'b0;
        put(DW'(16'hBEEF)); cycle();
        put(DW'(16'hCAFE)); cycle();
        RESET = 1'b1; FLUSH = 1'b1;
        cycle();
        chk("t6_valid", OUT_VALID, 1'b0);
        chk("t6_ready", IN_READY, 1'b0);
        chk("t6_cnt", STALL_CNT, 0);
        chk("t6_data", OUT_DATA, 0);
        chk("t6_ctrl", OUT_CTRL, BUBBLE);
        RESET = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0;
        cycle();

        // Random soak; upstream keeps its entry stable until accepted
        put({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 10000; i++) begin
            IN_VALID  = ($urandom_range(0, 3) != 0);
            OUT_READY = ($urandom_range(0, 3) != 0);
            FLUSH     = ($urandom_range(0, 63) == 0);
            cycle();
            if (m_acc) begin
                IN_DATA = {$urandom, $urandom, $urandom, $urandom};
                IN_CTRL = CW'($urandom);
            end
        end
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        cycle();
        cycle();
        chk("soak_empty", OUT_VALID, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
